// File: rtl/pc_unit_pkg.sv
// Shared definitions for the program-counter stage.
// Holds the pcSrc encoding produced by unit_control and consumed by pc_unit.
package pc_unit_pkg;

  typedef enum logic [2:0] {
    PC_SRC_RET  = 3'b000,
    PC_SRC_BR   = 3'b001,
    PC_SRC_SEQ  = 3'b010,
    PC_SRC_JMP  = 3'b011,
    PC_SRC_HALT = 3'b101
  } pc_src_e;

endpackage

// File: rtl/pc_unit_return_stack.sv
// return_stack: LIFO of return addresses for CALL/RET.
// Ports:
//   clk, reset      rising-edge clock, synchronous active-high reset
//   en              qualifies push/pop (one action per instruction)
//   push, pop       stack operation; both set overwrites the top entry
//   din             value pushed / written over the top
//   top             entry at sp-1 (don't-care when empty)
//   empty, full     combinational from sp
//   ovf, unf        sticky: push while full / pop while empty
module return_stack #(
  parameter int unsigned W     = 32,
  parameter int unsigned DEPTH = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] top,
  output logic         empty,
  output logic         full,
  output logic         ovf,
  output logic         unf
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned SP_W = AW + 1;

  logic [W-1:0]    mem [DEPTH];
  logic [SP_W-1:0] sp;
  logic [SP_W-1:0] sp_m1;

  assign sp_m1 = sp - SP_W'(1);
  assign empty = (sp == '0);
  assign full  = (sp == SP_W'(DEPTH));
  assign top   = mem[sp_m1[AW-1:0]];

  // Push with pop on an empty stack degenerates to a plain push.
  logic do_push, do_over;
  assign do_push = push && (!pop || empty);
  assign do_over = push && pop && !empty;

  // NOTE: storage has no reset; contents are don't-care until pushed and
  // leaving it out lets the array map onto plain RAM/regfile cells.
  always_ff @(posedge clk) begin
    if (en) begin
      if (do_push && !full) mem[sp[AW-1:0]] <= din;
      else if (do_over)     mem[sp_m1[AW-1:0]] <= din;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      sp  <= '0;
      ovf <= 1'b0;
      unf <= 1'b0;
    end else if (en) begin
      if (do_push) begin
        if (!full) sp <= sp + SP_W'(1);
        else       ovf <= 1'b1;
      end else if (pop && !push) begin
        if (!empty) sp <= sp_m1;
        else        unf <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/pc_unit.sv
// pc_unit: program counter, halt latch and next-PC mux of the MUSA core.
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   pc_write          one-cycle pulse per instruction; qualifies all updates
//   pc_src            next-PC source select (see pc_unit_pkg)
//   push, pop         CALL / RET stack controls (levels)
//   branch_taken      selects branch_addr for pc_src=BR
//   branch_addr       branch / call target
//   jump_addr         absolute jump target
//   pc                registered current instruction address
//   halted            sticky HALT flag
//   stack_empty/full  return stack occupancy
//   stack_ovf/unf     sticky stack error flags
module pc_unit #(
  parameter int unsigned         PC_W        = 32,
  parameter int unsigned         STACK_DEPTH = 8,
  parameter logic [PC_W-1:0]     RESET_PC    = '0,
  parameter int unsigned         PC_STEP     = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            pc_write,
  input  logic [2:0]      pc_src,
  input  logic            push,
  input  logic            pop,
  input  logic            branch_taken,
  input  logic [PC_W-1:0] branch_addr,
  input  logic [PC_W-1:0] jump_addr,
  output logic [PC_W-1:0] pc,
  output logic            halted,
  output logic            stack_empty,
  output logic            stack_full,
  output logic            stack_ovf,
  output logic            stack_unf
);
  import pc_unit_pkg::*;

  logic            en;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] pc_next;
  logic [PC_W-1:0] stk_top;
  logic            stk_unf;
  logic            halt_now;
  logic            ret_unf_set;
  logic            ret_unf;

  assign en     = pc_write && !halted;
  assign pc_inc = pc + PC_W'(PC_STEP);

  return_stack #(
    .W     (PC_W),
    .DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .push  (push),
    .pop   (pop),
    .din   (pc_inc),
    .top   (stk_top),
    .empty (stack_empty),
    .full  (stack_full),
    .ovf   (stack_ovf),
    .unf   (stk_unf)
  );

  // NOTE: every output of this block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    pc_next     = pc_inc;
    halt_now    = 1'b0;
    ret_unf_set = 1'b0;
    case (pc_src)
      PC_SRC_RET:  if (!stack_empty) pc_next = stk_top;
                   else              ret_unf_set = 1'b1;
      PC_SRC_BR:   if (branch_taken) pc_next = branch_addr;
      PC_SRC_JMP:  pc_next = jump_addr;
      PC_SRC_HALT: begin
        pc_next  = pc;
        halt_now = 1'b1;
      end
      default:     pc_next = pc_inc;  // SEQ and unused codes
    endcase
  end

  // A RET on an empty stack flags underflow even if control did not raise pop.
  assign stack_unf = stk_unf || ret_unf;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc      <= RESET_PC;
      halted  <= 1'b0;
      ret_unf <= 1'b0;
    end else if (en) begin
      pc <= pc_next;
      if (halt_now)    halted  <= 1'b1;
      if (ret_unf_set) ret_unf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
module tb_pc_unit;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        pc_write = 1'b0;
  logic [2:0]  pc_src = 3'b010;
  logic        push = 1'b0;
  logic        pop = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_addr = '0;
  logic [31:0] jump_addr = '0;
  logic [31:0] pc;
  logic        halted, stack_empty, stack_full, stack_ovf, stack_unf;

  always #5 clk = ~clk;

  pc_unit #(.PC_W(32), .STACK_DEPTH(DEPTH), .RESET_PC(32'h0), .PC_STEP(1)) dut (
    .clk(clk), .reset(reset), .pc_write(pc_write), .pc_src(pc_src),
    .push(push), .pop(pop), .branch_taken(branch_taken),
    .branch_addr(branch_addr), .jump_addr(jump_addr), .pc(pc),
    .halted(halted), .stack_empty(stack_empty), .stack_full(stack_full),
    .stack_ovf(stack_ovf), .stack_unf(stack_unf)
  );

  typedef struct packed {
    logic        halted;
    logic        empty;
    logic        full;
    logic        ovf;
    logic        unf;
    logic [31:0] pc;
  } obs_t;

  typedef struct {
    obs_t  exp;
    string name;
  } sb_t;

  sb_t sb_q[$];
  int  checks = 0;
  int  failures = 0;

  // Reference model: architectural state only.
  logic [31:0] m_pc;
  logic        m_halted, m_ovf, m_unf;
  logic [31:0] m_stack[$];

  task automatic check(input string name, input obs_t act, input obs_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got pc=%h h=%b e=%b f=%b o=%b u=%b, need pc=%h h=%b e=%b f=%b o=%b u=%b",
               name, act.pc, act.halted, act.empty, act.full, act.ovf, act.unf,
               exp.pc, exp.halted, exp.empty, exp.full, exp.ovf, exp.unf);
    end
  endtask

  function automatic obs_t model_obs();
    obs_t o;
    o.pc     = m_pc;
    o.halted = m_halted;
    o.empty  = (m_stack.size() == 0);
    o.full   = (m_stack.size() == DEPTH);
    o.ovf    = m_ovf;
    o.unf    = m_unf;
    return o;
  endfunction

  task automatic model_step(input logic rst, input logic pw, input logic [2:0] src,
                            input logic pu, input logic po, input logic tk,
                            input logic [31:0] ba, input logic [31:0] ja);
    logic [31:0] inc, nxt;
    if (rst) begin
      m_pc = 32'h0; m_halted = 0; m_ovf = 0; m_unf = 0;
      m_stack.delete();
      return;
    end
    if (!pw || m_halted) return;
    inc = m_pc + 32'd1;
    case (src)
      3'b000: begin
        if (m_stack.size() > 0) nxt = m_stack[$];
        else begin nxt = inc; m_unf = 1; end
      end
      3'b001: nxt = tk ? ba : inc;
      3'b011: nxt = ja;
      3'b101: begin nxt = m_pc; m_halted = 1; end
      default: nxt = inc;
    endcase
    if (pu && !po) begin
      if (m_stack.size() < DEPTH) m_stack.push_back(inc);
      else m_ovf = 1;
    end else if (po && !pu) begin
      if (m_stack.size() > 0) void'(m_stack.pop_back());
      else m_unf = 1;
    end else if (pu && po) begin
      if (m_stack.size() == 0) m_stack.push_back(inc);
      else m_stack[m_stack.size()-1] = inc;
    end
    m_pc = nxt;
  endtask

  // One clock of stimulus; expected post-edge state goes to the scoreboard.
  task automatic cyc(input string name, input logic rst, input logic pw,
                     input logic [2:0] src, input logic pu = 0, input logic po = 0,
                     input logic tk = 0, input logic [31:0] ba = 0,
                     input logic [31:0] ja = 0);
    sb_t e;
    @(negedge clk);
    reset = rst; pc_write = pw; pc_src = src; push = pu; pop = po;
    branch_taken = tk; branch_addr = ba; jump_addr = ja;
    model_step(rst, pw, src, pu, po, tk, ba, ja);
    e.exp  = model_obs();
    e.name = name;
    sb_q.push_back(e);
  endtask

  // Monitor: sample 1 time unit after each edge and compare with the queue.
  initial begin
    obs_t act;
    sb_t  e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        act = '{halted: halted, empty: stack_empty, full: stack_full,
                ovf: stack_ovf, unf: stack_unf, pc: pc};
        check(e.name, act, e.exp);
      end
    end
  end

  initial begin
    int r;
    cyc("reset", 1, 0, 3'b010);
    cyc("reset_pw_override", 1, 1, 3'b011, 0, 0, 0, 0, 32'h99);
    for (int i = 0; i < 3; i++) begin
      cyc("seq", 0, 1, 3'b010);
      cyc("idle_hold", 0, 0, 3'b011, 1, 0, 1, 32'h5, 32'h7);
    end
    cyc("jmp5", 0, 1, 3'b011, 0, 0, 0, 0, 32'h5);
    cyc("br_taken", 0, 1, 3'b001, 0, 0, 1, 32'h40);
    cyc("br_not_taken", 0, 1, 3'b001, 0, 0, 0, 32'h77);
    cyc("jmp10", 0, 1, 3'b011, 0, 0, 0, 0, 32'h10);
    cyc("call", 0, 1, 3'b001, 1, 0, 1, 32'h80);
    cyc("ret", 0, 1, 3'b000, 0, 1);
    for (int i = 0; i < 9; i++)
      cyc("nested_call", 0, 1, 3'b001, 1, 0, 1, 32'h100 + 32'(i) * 32'h10);
    for (int i = 0; i < 8; i++)
      cyc("nested_ret", 0, 1, 3'b000, 0, 1);
    cyc("jmp20", 0, 1, 3'b011, 0, 0, 0, 0, 32'h20);
    cyc("ret_empty", 0, 1, 3'b000, 0, 1);
    cyc("jmp_top", 0, 1, 3'b011, 0, 0, 0, 0, 32'hFFFF_FFFF);
    cyc("wrap", 0, 1, 3'b111);
    cyc("call_wrap", 0, 1, 3'b001, 1, 0, 1, 32'h30);
    cyc("push_pop_over", 0, 1, 3'b010, 1, 1);
    cyc("ret_over", 0, 1, 3'b000, 0, 1);
    cyc("rst_mid", 1, 0, 3'b010);
    cyc("jmp7", 0, 1, 3'b011, 0, 0, 0, 0, 32'h7);
    cyc("halt", 0, 1, 3'b101);
    for (int i = 0; i < 10; i++)
      cyc("halt_hold", 0, 1, 3'b011, 1, 0, 1, 32'h3, 32'h9);
    cyc("reset_after_halt", 1, 0, 3'b010);

    for (int i = 0; i < 800; i++) begin
      logic [2:0]  s;
      logic        pu, po, pw, rs;
      r  = $urandom_range(0, 99);
      rs = (r < 2);
      pw = ($urandom_range(0, 99) < 60);
      r  = $urandom_range(0, 99);
      s  = (r < 30) ? 3'b010 : (r < 50) ? 3'b001 : (r < 70) ? 3'b000 :
           (r < 82) ? 3'b011 : (r < 85) ? 3'b101 : 3'($urandom_range(4, 7));
      pu = ($urandom_range(0, 99) < 35);
      po = (s == 3'b000) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 99) < 10);
      cyc("random", rs, pw, s, pu, po, 1'($urandom()), $urandom(), $urandom());
    end

    @(negedge clk);
    reset = 0; pc_write = 0; push = 0; pop = 0;
    @(negedge clk);
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
